// File: rtl/bnn_bram_pkg.sv
// Shared definitions for BNN BRAM helpers: sequencer states, BRAM geometry
// and byte-address helpers.
package bnn_bram_pkg;

   localparam int BRAM_ADDR_W = 32;
   localparam int BRAM_DATA_W = 32;
   localparam logic [BRAM_ADDR_W-1:0] WORD_BYTES = 4;
   localparam logic [3:0] WE_ALL = 4'hF;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } seq_state_t;

   // Byte addresses are word-aligned: the two low bits are forced to zero.
   function automatic logic [BRAM_ADDR_W-1:0] word_addr(input logic [BRAM_ADDR_W-1:0] a);
      return a & ~(BRAM_ADDR_W'(3));
   endfunction

endpackage

// File: rtl/bram_copy_sequencer_if.sv
// Bundle of the control handshake and both Xilinx BRAM ports of the copy
// sequencer.
//
// Handshake: start is a level request taken on a clock edge where ready=1;
// that edge latches src_base/dst_base/len and drops ready. Any start seen
// while ready=0 is dropped, nothing is queued. done pulses for exactly one
// cycle after the last write has been issued, and ready rises one cycle later.
interface bram_copy_sequencer_if #(parameter int LEN_W = 16) ();
   import bnn_bram_pkg::*;

   // control side
   logic                   start;
   logic [BRAM_ADDR_W-1:0] src_base;
   logic [BRAM_ADDR_W-1:0] dst_base;
   logic [LEN_W-1:0]       len;
   logic                   ready;
   logic                   done;
   // BRAM port A (source, read-only)
   logic                   clka;
   logic                   rsta;
   logic                   ena;
   logic [BRAM_ADDR_W-1:0] addra;
   logic [BRAM_DATA_W-1:0] dina;
   logic [3:0]             wea;
   logic [BRAM_DATA_W-1:0] douta;
   // BRAM port B (destination, write-only)
   logic                   clkb;
   logic                   rstb;
   logic                   enb;
   logic [BRAM_ADDR_W-1:0] addrb;
   logic [BRAM_DATA_W-1:0] dinb;
   logic [3:0]             web;
   logic [BRAM_DATA_W-1:0] doutb;
   // debug view of the sequencer FSM
   seq_state_t             dbg_state;

   // Sequencer side; doutb is never read by the sequencer.
   modport slave (
      input  start, src_base, dst_base, len, douta,
      output ready, done,
      output clka, rsta, ena, addra, dina, wea,
      output clkb, rstb, enb, addrb, dinb, web,
      output dbg_state
   );

   // Controller plus BRAM side.
   modport master (
      output start, src_base, dst_base, len, douta, doutb,
      input  ready, done,
      input  clka, rsta, ena, addra, dina, wea,
      input  clkb, rstb, enb, addrb, dinb, web,
      input  dbg_state
   );

endinterface

// File: rtl/bram_rd_align.sv
// Shift register that carries {valid, dst_addr} alongside a BRAM read so the
// matching write side lines up with the read data RD_LATENCY cycles later.
module bram_rd_align
   import bnn_bram_pkg::*;
#(
   parameter int RD_LATENCY = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [BRAM_ADDR_W-1:0] in_addr,
   output logic                   out_valid,
   output logic [BRAM_ADDR_W-1:0] out_addr,
   output logic                   pending
);

   logic [RD_LATENCY-1:0]  vld;
   logic [BRAM_ADDR_W-1:0] adr [RD_LATENCY];

   // Shift one stage per cycle; empty slots carry a zero address.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
         for (int i = 0; i < RD_LATENCY; i++) adr[i] <= '0;
      end else begin
         vld[0] <= in_valid;
         adr[0] <= in_valid ? in_addr : '0;
         for (int i = 1; i < RD_LATENCY; i++) begin
            vld[i] <= vld[i-1];
            adr[i] <= adr[i-1];
         end
      end
   end

   // pending: something still has to reach the output after the next edge
   // (an entry entering now or one sitting in a non-final stage).
   always_comb begin
      pending = in_valid;
      for (int i = 0; i < RD_LATENCY - 1; i++) pending = pending | vld[i];
   end

   assign out_valid = vld[RD_LATENCY-1];
   assign out_addr  = adr[RD_LATENCY-1];

endmodule

// File: rtl/bram_copy_sequencer.sv
// DMA-style copy of LEN consecutive words from a source BRAM (port A) to a
// destination BRAM (port B), one word per cycle.
module bram_copy_sequencer
   import bnn_bram_pkg::*;
#(
   parameter int LEN_W      = 16,
   parameter int RD_LATENCY = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   bram_copy_sequencer_if.slave         bus
);

   seq_state_t             state;
   logic                   ready_q;
   logic                   done_q;
   logic                   ena_q;
   logic [BRAM_ADDR_W-1:0] addra_q;
   logic [BRAM_ADDR_W-1:0] dst_q;
   // Words left to read after the one currently on port A; counting down
   // keeps the counter at LEN_W bits even for the largest len.
   logic [LEN_W-1:0]       remaining;

   logic                   wr_valid;
   logic [BRAM_ADDR_W-1:0] wr_addr;
   logic                   align_pending;

   // Sequencer FSM: latches a request, walks the read addresses, waits for
   // the delay line to empty and pulses done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         ena_q     <= 1'b0;
         addra_q   <= '0;
         dst_q     <= '0;
         remaining <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  ready_q <= 1'b0;
                  addra_q <= word_addr(bus.src_base);
                  dst_q   <= word_addr(bus.dst_base);
                  if (bus.len == '0) begin
                     state  <= S_DONE;
                     done_q <= 1'b1;
                  end else begin
                     state     <= S_READ;
                     ena_q     <= 1'b1;
                     remaining <= bus.len - LEN_W'(1);
                  end
               end
            end
            S_READ: begin
               if (remaining == '0) begin
                  ena_q <= 1'b0;
                  state <= S_DRAIN;
               end else begin
                  addra_q   <= addra_q + WORD_BYTES;
                  dst_q     <= dst_q + WORD_BYTES;
                  remaining <= remaining - LEN_W'(1);
               end
            end
            S_DRAIN: begin
               if (!align_pending) begin
                  state  <= S_DONE;
                  done_q <= 1'b1;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // The destination address rides with each read and pops out in the cycle
   // the BRAM presents that read's data.
   bram_rd_align #(
      .RD_LATENCY (RD_LATENCY)
   ) u_align (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (ena_q),
      .in_addr   (dst_q),
      .out_valid (wr_valid),
      .out_addr  (wr_addr),
      .pending   (align_pending)
   );

   assign bus.ready     = ready_q;
   assign bus.done      = done_q;
   assign bus.clka      = clk;
   assign bus.clkb      = clk;
   assign bus.rsta      = rst;
   assign bus.rstb      = rst;
   assign bus.ena       = ena_q;
   assign bus.addra     = addra_q;
   assign bus.dina      = '0;
   assign bus.wea       = '0;
   assign bus.enb       = wr_valid;
   assign bus.addrb     = wr_addr;
   // douta is valid in exactly the cycle wr_valid is set, so it passes
   // straight through to port B.
   assign bus.dinb      = wr_valid ? bus.douta : '0;
   assign bus.web       = wr_valid ? WE_ALL : 4'h0;
   assign bus.dbg_state = state;

endmodule

// File: tb/tb_bram_copy_sequencer.sv
// Bench for bram_copy_sequencer: one instance with RD_LATENCY=1 and one with
// RD_LATENCY=2, each fed by a small source BRAM model.
module tb_bram_copy_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cyc = '0;

   int n_checks = 0;
   int n_err    = 0;

   logic [31:0] mem [64];

   logic [63:0] exp_rd1 [$];
   logic [95:0] exp_wr1 [$];
   logic [31:0] exp_dn1 [$];
   logic [63:0] exp_rd2 [$];
   logic [95:0] exp_wr2 [$];
   logic [31:0] exp_dn2 [$];

   bram_copy_sequencer_if #(.LEN_W(16)) bus1 ();
   bram_copy_sequencer_if #(.LEN_W(16)) bus2 ();

   bram_copy_sequencer #(.LEN_W(16), .RD_LATENCY(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   bram_copy_sequencer #(.LEN_W(16), .RD_LATENCY(2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   // ---------------- clock / reset / cycle counter ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- source BRAM models ----------------
   logic [31:0] p1, p2a, p2b;
   always @(posedge clk) begin
      if (bus1.ena) p1 <= mem[bus1.addra[7:2]];
      if (bus2.ena) p2a <= mem[bus2.addra[7:2]];
      p2b <= p2a;
   end
   assign bus1.douta = p1;
   assign bus2.douta = p2b;
   assign bus1.doutb = '0;
   assign bus2.doutb = '0;

   // ---------------- check helpers ----------------
   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name, input logic [95:0] act);
      n_checks++;
      n_err++;
      $display("FAIL %s: unexpected event %h (cycle %0d)", name, act, cyc);
   endtask

   task automatic wait_until(input logic [31:0] c);
      int guard = 0;
      while (cyc < c && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc < c) unexpected("wait_timeout", {64'd0, c});
   endtask

   // Expected events of a whole transfer on instance 1 (cycle 0 = start edge).
   task automatic push_xfer1(input logic [31:0] base, input logic [31:0] src,
                             input logic [31:0] dst, input int n);
      logic [31:0] a;
      for (int k = 0; k < n; k++) begin
         a = src + 32'(4 * k);
         exp_rd1.push_back({base + 32'(1 + k), a});
         exp_wr1.push_back({base + 32'(2 + k), dst + 32'(4 * k), mem[a[7:2]]});
      end
      exp_dn1.push_back(base + 32'(n + 2));
   endtask

   task automatic check_reset1(input string tag);
      check({tag, "_ready"}, bus1.ready, 1'b1);
      check({tag, "_done"},  bus1.done,  1'b0);
      check({tag, "_ena"},   bus1.ena,   1'b0);
      check({tag, "_addra"}, bus1.addra, 32'h0);
      check({tag, "_enb"},   bus1.enb,   1'b0);
      check({tag, "_addrb"}, bus1.addrb, 32'h0);
      check({tag, "_dinb"},  bus1.dinb,  32'h0);
      check({tag, "_web"},   bus1.web,   4'h0);
   endtask

   // ---------------- scoreboard monitors ----------------
   logic [95:0] e;
   always @(negedge clk) begin
      if (bus1.ena) begin
         if (exp_rd1.size() == 0) unexpected("rd1", {32'd0, cyc, bus1.addra});
         else begin e = 96'(exp_rd1.pop_front()); check("rd1", {32'd0, cyc, bus1.addra}, e); end
      end
      if (bus1.enb) begin
         check("web1", bus1.web, 4'hF);
         if (exp_wr1.size() == 0) unexpected("wr1", {cyc, bus1.addrb, bus1.dinb});
         else begin e = exp_wr1.pop_front(); check("wr1", {cyc, bus1.addrb, bus1.dinb}, e); end
      end else begin
         check("idle_portb1", {bus1.web, bus1.dinb}, 36'h0);
      end
      if (bus1.done) begin
         if (exp_dn1.size() == 0) unexpected("done1", cyc);
         else begin e = 96'(exp_dn1.pop_front()); check("done1", cyc, e); end
      end
      check("porta_wr1", {bus1.wea, bus1.dina}, 36'h0);
   end

   logic [95:0] e2;
   always @(negedge clk) begin
      if (bus2.ena) begin
         if (exp_rd2.size() == 0) unexpected("rd2", {32'd0, cyc, bus2.addra});
         else begin e2 = 96'(exp_rd2.pop_front()); check("rd2", {32'd0, cyc, bus2.addra}, e2); end
      end
      if (bus2.enb) begin
         check("web2", bus2.web, 4'hF);
         if (exp_wr2.size() == 0) unexpected("wr2", {cyc, bus2.addrb, bus2.dinb});
         else begin e2 = exp_wr2.pop_front(); check("wr2", {cyc, bus2.addrb, bus2.dinb}, e2); end
      end
      if (bus2.done) begin
         if (exp_dn2.size() == 0) unexpected("done2", cyc);
         else begin e2 = 96'(exp_dn2.pop_front()); check("done2", cyc, e2); end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   logic [31:0] base;
   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
      mem[0] = 32'hDEADBEEF;
      mem[1] = 32'h1;
      mem[2] = 32'h2;
      mem[3] = 32'h3;
      bus1.start = 1'b0; bus1.src_base = '0; bus1.dst_base = '0; bus1.len = '0;
      bus2.start = 1'b0; bus2.src_base = '0; bus2.dst_base = '0; bus2.len = '0;

      // reset
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset1("rst");
      check("rst_ready2", bus2.ready, 1'b1);
      rst = 1'b0;
      @(negedge clk);

      // len=4 copy, RD_LATENCY=1
      base = cyc;
      exp_rd1.push_back({base + 1, 32'h0});
      exp_rd1.push_back({base + 2, 32'h4});
      exp_rd1.push_back({base + 3, 32'h8});
      exp_rd1.push_back({base + 4, 32'hC});
      exp_wr1.push_back({base + 2, 32'h100, 32'hDEADBEEF});
      exp_wr1.push_back({base + 3, 32'h104, 32'h1});
      exp_wr1.push_back({base + 4, 32'h108, 32'h2});
      exp_wr1.push_back({base + 5, 32'h10C, 32'h3});
      exp_dn1.push_back(base + 6);
      bus1.start = 1'b1; bus1.src_base = 32'h0; bus1.dst_base = 32'h100; bus1.len = 16'd4;
      @(negedge clk);
      bus1.start = 1'b0;
      wait_until(base + 6);
      check("t1_ready_c6", bus1.ready, 1'b0);
      wait_until(base + 7);
      check("t1_ready_c7", bus1.ready, 1'b1);
      wait_until(base + 9);

      // len=0
      base = cyc;
      exp_dn1.push_back(base + 1);
      bus1.start = 1'b1; bus1.src_base = 32'h40; bus1.dst_base = 32'h800; bus1.len = 16'd0;
      @(negedge clk);
      bus1.start = 1'b0;
      check("t2_ready_c1", bus1.ready, 1'b0);
      @(negedge clk);
      check("t2_ready_c2", bus1.ready, 1'b1);
      wait_until(base + 5);

      // RD_LATENCY=2, len=3
      base = cyc;
      exp_rd2.push_back({base + 1, 32'h10});
      exp_rd2.push_back({base + 2, 32'h14});
      exp_rd2.push_back({base + 3, 32'h18});
      exp_wr2.push_back({base + 3, 32'h200, 32'hC0DE0004});
      exp_wr2.push_back({base + 4, 32'h204, 32'hC0DE0005});
      exp_wr2.push_back({base + 5, 32'h208, 32'hC0DE0006});
      exp_dn2.push_back(base + 6);
      bus2.start = 1'b1; bus2.src_base = 32'h10; bus2.dst_base = 32'h200; bus2.len = 16'd3;
      @(negedge clk);
      bus2.start = 1'b0;
      wait_until(base + 6);
      check("t3_ready_c6", bus2.ready, 1'b0);
      wait_until(base + 7);
      check("t3_ready_c7", bus2.ready, 1'b1);
      wait_until(base + 9);

      // len=8 with an ignored start pulse in cycle 3
      base = cyc;
      push_xfer1(base, 32'h20, 32'h300, 8);
      bus1.start = 1'b1; bus1.src_base = 32'h20; bus1.dst_base = 32'h300; bus1.len = 16'd8;
      @(negedge clk);
      bus1.start = 1'b0;
      wait_until(base + 3);
      bus1.start = 1'b1; bus1.src_base = 32'h0; bus1.dst_base = 32'h700; bus1.len = 16'd2;
      @(negedge clk);
      bus1.start = 1'b0;
      wait_until(base + 11);
      check("t4_ready_c11", bus1.ready, 1'b1);
      wait_until(base + 16);
      check("t4_wr_left", exp_wr1.size(), 0);
      check("t4_dn_left", exp_dn1.size(), 0);

      // reset in cycle 3 of a len=8 transfer, then a len=2 transfer
      base = cyc;
      exp_rd1.push_back({base + 1, 32'h40});
      exp_rd1.push_back({base + 2, 32'h44});
      exp_rd1.push_back({base + 3, 32'h48});
      exp_wr1.push_back({base + 2, 32'h400, 32'hC0DE0010});
      exp_wr1.push_back({base + 3, 32'h404, 32'hC0DE0011});
      bus1.start = 1'b1; bus1.src_base = 32'h40; bus1.dst_base = 32'h400; bus1.len = 16'd8;
      @(negedge clk);
      bus1.start = 1'b0;
      wait_until(base + 3);
      rst = 1'b1;
      @(negedge clk);
      check_reset1("abort");
      rst = 1'b0;
      wait_until(base + 14);
      check("t5_rd_left", exp_rd1.size(), 0);
      check("t5_wr_left", exp_wr1.size(), 0);
      base = cyc;
      exp_rd1.push_back({base + 1, 32'h8});
      exp_rd1.push_back({base + 2, 32'hC});
      exp_wr1.push_back({base + 2, 32'h500, 32'h2});
      exp_wr1.push_back({base + 3, 32'h504, 32'h3});
      exp_dn1.push_back(base + 4);
      bus1.start = 1'b1; bus1.src_base = 32'h8; bus1.dst_base = 32'h500; bus1.len = 16'd2;
      @(negedge clk);
      bus1.start = 1'b0;
      wait_until(base + 5);
      check("t5_ready_c5", bus1.ready, 1'b1);
      wait_until(base + 8);

      // start held high, len=2, source address wraps to 0
      base = cyc;
      exp_rd1.push_back({base + 1, 32'hFFFFFFFC});
      exp_rd1.push_back({base + 2, 32'h0});
      exp_wr1.push_back({base + 2, 32'h600, 32'hC0DE003F});
      exp_wr1.push_back({base + 3, 32'h604, 32'hDEADBEEF});
      exp_dn1.push_back(base + 4);
      exp_rd1.push_back({base + 6, 32'hFFFFFFFC});
      exp_rd1.push_back({base + 7, 32'h0});
      exp_wr1.push_back({base + 7, 32'h600, 32'hC0DE003F});
      exp_wr1.push_back({base + 8, 32'h604, 32'hDEADBEEF});
      exp_dn1.push_back(base + 9);
      bus1.start = 1'b1; bus1.src_base = 32'hFFFFFFFC; bus1.dst_base = 32'h600; bus1.len = 16'd2;
      wait_until(base + 5);
      check("t6_ready_c5", bus1.ready, 1'b1);
      wait_until(base + 6);
      bus1.start = 1'b0;
      check("t6_ready_c6", bus1.ready, 1'b0);
      wait_until(base + 10);
      check("t6_ready_c10", bus1.ready, 1'b1);
      wait_until(base + 14);

      // everything expected must have been seen
      check("end_rd1", exp_rd1.size(), 0);
      check("end_wr1", exp_wr1.size(), 0);
      check("end_dn1", exp_dn1.size(), 0);
      check("end_rd2", exp_rd2.size(), 0);
      check("end_wr2", exp_wr2.size(), 0);
      check("end_dn2", exp_dn2.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
